// File: rtl/triangle_rasterizer.sv
// Triangle scan converter: latches one screen-space triangle, derives a
// clamped bounding box and three edge functions, then walks the box one
// candidate pixel per cycle and streams covered pixels over valid/ready.
module triangle_rasterizer #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 180,
    parameter int COLOR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic signed [9:0]  tri_x0,
    input  logic signed [9:0]  tri_x1,
    input  logic signed [9:0]  tri_x2,
    input  logic signed [8:0]  tri_y0,
    input  logic signed [8:0]  tri_y1,
    input  logic signed [8:0]  tri_y2,
    input  logic [COLOR_W-1:0] tri_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [8:0]         pix_x,
    output logic [7:0]         pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               done
);

    localparam logic signed [10:0] X_LAST_C = 11'(H_RES - 1);
    localparam logic signed [10:0] Y_LAST_C = 11'(V_RES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BBOX  = 3'd1,
        ST_EDGE  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t              state_q;
    logic signed [10:0]  vx_q [3];
    logic signed [10:0]  vy_q [3];
    logic [COLOR_W-1:0]  color_q;
    logic [8:0]          xmin_q, xmax_q, cx_q;
    logic [7:0]          ymin_q, ymax_q, cy_q;
    logic signed [10:0]  dx_q [3];
    logic signed [10:0]  dy_q [3];
    logic signed [23:0]  e_q [3];
    logic signed [23:0]  erow_q [3];
    logic                sign_q;

    logic                tri_ready_q, pix_valid_q, done_q;
    logic [8:0]          pix_x_q;
    logic [7:0]          pix_y_q;
    logic [COLOR_W-1:0]  pix_color_q;

    logic signed [10:0]  bx_min_d, bx_max_d, by_min_d, by_max_d;
    logic signed [10:0]  xmin_cl_d, xmax_cl_d, ymin_cl_d, ymax_cl_d;
    logic                off_d;
    logic signed [10:0]  dx_d [3];
    logic signed [10:0]  dy_d [3];
    logic signed [23:0]  einit_d [3];
    logic signed [23:0]  area_d;
    logic signed [23:0]  e_xstep_d [3];
    logic signed [23:0]  erow_next_d [3];
    logic                cov_d, adv_d;

    function automatic logic signed [10:0] min3(input logic signed [10:0] a,
                                                input logic signed [10:0] b,
                                                input logic signed [10:0] c);
        logic signed [10:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [10:0] max3(input logic signed [10:0] a,
                                                input logic signed [10:0] b,
                                                input logic signed [10:0] c);
        logic signed [10:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                                 input logic signed [10:0] hi);
        return (v < 11'sd0) ? 11'sd0 : ((v > hi) ? hi : v);
    endfunction

    // Edge function (px-ax)*dy - (py-ay)*dx; all operands pre-extended so
    // the 22-bit products and 24-bit difference cannot overflow.
    function automatic logic signed [23:0] edge_at(input logic signed [10:0] px,
                                                   input logic signed [10:0] py,
                                                   input logic signed [10:0] ax,
                                                   input logic signed [10:0] ay,
                                                   input logic signed [10:0] dx,
                                                   input logic signed [10:0] dy);
        logic signed [21:0] rx, ry, mx, my, p1, p2;
        rx = {{11{px[10]}}, px} - {{11{ax[10]}}, ax};
        ry = {{11{py[10]}}, py} - {{11{ay[10]}}, ay};
        mx = {{11{dx[10]}}, dx};
        my = {{11{dy[10]}}, dy};
        p1 = rx * my;
        p2 = ry * mx;
        return {{2{p1[21]}}, p1} - {{2{p2[21]}}, p2};
    endfunction

    // Bounding box over the latched vertices, off-screen test and clamping.
    always_comb begin
        bx_min_d  = min3(vx_q[0], vx_q[1], vx_q[2]);
        bx_max_d  = max3(vx_q[0], vx_q[1], vx_q[2]);
        by_min_d  = min3(vy_q[0], vy_q[1], vy_q[2]);
        by_max_d  = max3(vy_q[0], vy_q[1], vy_q[2]);
        off_d     = (bx_max_d < 11'sd0) || (bx_min_d > X_LAST_C) ||
                    (by_max_d < 11'sd0) || (by_min_d > Y_LAST_C);
        xmin_cl_d = clamp(bx_min_d, X_LAST_C);
        xmax_cl_d = clamp(bx_max_d, X_LAST_C);
        ymin_cl_d = clamp(by_min_d, Y_LAST_C);
        ymax_cl_d = clamp(by_max_d, Y_LAST_C);
    end

    // Edge deltas, edge values at the box origin, and the signed area.
    always_comb begin
        dx_d[0]    = vx_q[1] - vx_q[0];
        dx_d[1]    = vx_q[2] - vx_q[1];
        dx_d[2]    = vx_q[0] - vx_q[2];
        dy_d[0]    = vy_q[1] - vy_q[0];
        dy_d[1]    = vy_q[2] - vy_q[1];
        dy_d[2]    = vy_q[0] - vy_q[2];
        einit_d[0] = edge_at($signed({2'b00, xmin_q}), $signed({3'b000, ymin_q}),
                             vx_q[0], vy_q[0], dx_d[0], dy_d[0]);
        einit_d[1] = edge_at($signed({2'b00, xmin_q}), $signed({3'b000, ymin_q}),
                             vx_q[1], vy_q[1], dx_d[1], dy_d[1]);
        einit_d[2] = edge_at($signed({2'b00, xmin_q}), $signed({3'b000, ymin_q}),
                             vx_q[2], vy_q[2], dx_d[2], dy_d[2]);
        area_d     = edge_at(vx_q[2], vy_q[2], vx_q[0], vy_q[0], dx_d[0], dy_d[0]);
    end

    // Incremental edge steps, coverage of the current candidate, and the
    // scan-advance condition (output register free or being drained now).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            e_xstep_d[i]   = e_q[i] + {{13{dy_q[i][10]}}, dy_q[i]};
            erow_next_d[i] = erow_q[i] - {{13{dx_q[i][10]}}, dx_q[i]};
        end
        if (sign_q) begin
            cov_d = (e_q[0] <= 24'sd0) && (e_q[1] <= 24'sd0) && (e_q[2] <= 24'sd0);
        end else begin
            cov_d = (e_q[0] >= 24'sd0) && (e_q[1] >= 24'sd0) && (e_q[2] >= 24'sd0);
        end
        adv_d = !pix_valid_q || pix_ready;
    end

    // Control FSM with the datapath registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tri_ready_q <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 9'd0;
            pix_y_q     <= 8'd0;
            pix_color_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pix_valid_q && pix_ready) begin
                pix_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tri_valid && tri_ready_q) begin
                        vx_q[0]     <= {tri_x0[9], tri_x0};
                        vx_q[1]     <= {tri_x1[9], tri_x1};
                        vx_q[2]     <= {tri_x2[9], tri_x2};
                        vy_q[0]     <= {{2{tri_y0[8]}}, tri_y0};
                        vy_q[1]     <= {{2{tri_y1[8]}}, tri_y1};
                        vy_q[2]     <= {{2{tri_y2[8]}}, tri_y2};
                        color_q     <= tri_color;
                        tri_ready_q <= 1'b0;
                        state_q     <= ST_BBOX;
                    end else begin
                        tri_ready_q <= 1'b1;
                    end
                end
                ST_BBOX: begin
                    xmin_q <= 9'(xmin_cl_d);
                    xmax_q <= 9'(xmax_cl_d);
                    ymin_q <= 8'(ymin_cl_d);
                    ymax_q <= 8'(ymax_cl_d);
                    state_q <= off_d ? ST_DRAIN : ST_EDGE;
                end
                ST_EDGE: begin
                    for (int i = 0; i < 3; i++) begin
                        dx_q[i]   <= dx_d[i];
                        dy_q[i]   <= dy_d[i];
                        e_q[i]    <= einit_d[i];
                        erow_q[i] <= einit_d[i];
                    end
                    sign_q  <= area_d < 24'sd0;
                    cx_q    <= xmin_q;
                    cy_q    <= ymin_q;
                    state_q <= (area_d == 24'sd0) ? ST_DRAIN : ST_SCAN;
                end
                ST_SCAN: begin
                    if (adv_d) begin
                        if (cov_d) begin
                            pix_valid_q <= 1'b1;
                            pix_x_q     <= cx_q;
                            pix_y_q     <= cy_q;
                            pix_color_q <= color_q;
                        end
                        if (cx_q == xmax_q) begin
                            if (cy_q == ymax_q) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                cx_q <= xmin_q;
                                cy_q <= cy_q + 8'd1;
                                for (int i = 0; i < 3; i++) begin
                                    erow_q[i] <= erow_next_d[i];
                                    e_q[i]    <= erow_next_d[i];
                                end
                            end
                        end else begin
                            cx_q <= cx_q + 9'd1;
                            for (int i = 0; i < 3; i++) begin
                                e_q[i] <= e_xstep_d[i];
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (adv_d) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tri_ready = tri_ready_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = pix_color_q;
    assign done      = done_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Randomized self-checking bench for triangle_rasterizer against a direct
// edge-function reference model evaluated pixel by pixel.
module tb_triangle_rasterizer;

    localparam int H_RES   = 320;
    localparam int V_RES   = 180;
    localparam int COLOR_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               tri_valid;
    logic               tri_ready;
    logic signed [9:0]  tri_x0, tri_x1, tri_x2;
    logic signed [8:0]  tri_y0, tri_y1, tri_y2;
    logic [COLOR_W-1:0] tri_color;
    logic               pix_valid;
    logic               pix_ready;
    logic [8:0]         pix_x;
    logic [7:0]         pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               done;

    triangle_rasterizer #(.H_RES(H_RES), .V_RES(V_RES), .COLOR_W(COLOR_W)) dut (
        .clk(clk), .rst(rst),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_x0(tri_x0), .tri_x1(tri_x1), .tri_x2(tri_x2),
        .tri_y0(tri_y0), .tri_y1(tri_y1), .tri_y2(tri_y2),
        .tri_color(tri_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int x; int y; int k; } pix_t;
    pix_t exp_q[$];
    int   tx[3];
    int   ty[3];
    int   exp_n;      // candidates in the clamped box
    int   exp_kind;   // 0 normal, 1 off-screen, 2 degenerate
    int   exp_total;

    task automatic check_value(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int edge_fn(int a, int b, int px, int py);
        return (px - tx[a]) * (ty[b] - ty[a]) - (py - ty[a]) * (tx[b] - tx[a]);
    endfunction

    function automatic int min3(int a, int b, int c);
        int m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Reference: visit every on-screen box pixel and test the three edges.
    task automatic build_model();
        int xmn, xmx, ymn, ymx, area, k, e0, e1, e2;
        exp_q.delete();
        exp_n = 0;
        xmn = min3(tx[0], tx[1], tx[2]);
        xmx = max3(tx[0], tx[1], tx[2]);
        ymn = min3(ty[0], ty[1], ty[2]);
        ymx = max3(ty[0], ty[1], ty[2]);
        if (xmx < 0 || xmn > H_RES - 1 || ymx < 0 || ymn > V_RES - 1) begin
            exp_kind = 1;
        end else begin
            xmn = (xmn < 0) ? 0 : xmn;
            ymn = (ymn < 0) ? 0 : ymn;
            xmx = (xmx > H_RES - 1) ? H_RES - 1 : xmx;
            ymx = (ymx > V_RES - 1) ? V_RES - 1 : ymx;
            exp_n = (xmx - xmn + 1) * (ymx - ymn + 1);
            area  = edge_fn(0, 1, tx[2], ty[2]);
            if (area == 0) begin
                exp_kind = 2;
            end else begin
                exp_kind = 0;
                k = 0;
                for (int y = ymn; y <= ymx; y++) begin
                    for (int x = xmn; x <= xmx; x++) begin
                        e0 = edge_fn(0, 1, x, y);
                        e1 = edge_fn(1, 2, x, y);
                        e2 = edge_fn(2, 0, x, y);
                        if ((area > 0 && e0 >= 0 && e1 >= 0 && e2 >= 0) ||
                            (area < 0 && e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
                            exp_q.push_back('{x: x, y: y, k: k});
                        end
                        k++;
                    end
                end
            end
        end
        exp_total = exp_q.size();
    endtask

    task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
        tx[0] = x0; ty[0] = y0;
        tx[1] = x1; ty[1] = y1;
        tx[2] = x2; ty[2] = y2;
    endtask

    // ready_mode 0: pix_ready held high; 1: random. stall_at / reset_at
    // select the pixel number (1-based) for a 10-cycle stall or a reset.
    task automatic run_tri(input int color, input int ready_mode, input int stall_at,
                           input int reset_at, input string name);
        int w, cyc, hs, dones, stall_left, stall_cycles, done_cyc, limit, exp_done;
        bit finished, stall_done;
        pix_t f;
        build_model();
        w = 0;
        while (tri_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check_value({name, "_tri_ready"}, int'(tri_ready), 1);
        tri_x0 = 10'(tx[0]); tri_x1 = 10'(tx[1]); tri_x2 = 10'(tx[2]);
        tri_y0 = 9'(ty[0]);  tri_y1 = 9'(ty[1]);  tri_y2 = 9'(ty[2]);
        tri_color = COLOR_W'(color);
        tri_valid = 1'b1;
        pix_ready = (ready_mode == 0);
        tick();
        tri_valid = 1'b0;
        tri_x0 = 10'sd0;
        cyc = 1; hs = 0; dones = 0; stall_left = 0; stall_cycles = 0;
        done_cyc = -1; finished = 1'b0; stall_done = 1'b0;
        limit = 8 * exp_n + 60;
        while (!finished && cyc < limit) begin
            if (done === 1'b1) begin
                dones++;
                done_cyc = cyc;
                check_value({name, "_left_at_done"}, exp_q.size(), 0);
                check_value({name, "_valid_at_done"}, int'(pix_valid), 0);
                tick();
                check_value({name, "_ready_after_done"}, int'(tri_ready), 1);
                check_value({name, "_done_single"}, int'(done), 0);
                finished = 1'b1;
            end else begin
                if (reset_at > 0 && pix_valid === 1'b1 && hs == reset_at - 1) begin
                    pix_ready = 1'b0;
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    check_value({name, "_rst_valid"}, int'(pix_valid), 0);
                    check_value({name, "_rst_done"}, int'(done), 0);
                    for (int i = 0; i < 6; i++) begin
                        tick();
                        check_value({name, "_post_rst_done"}, int'(done), 0);
                    end
                    return;
                end
                if (stall_at > 0 && !stall_done && stall_left == 0 &&
                    pix_valid === 1'b1 && hs == stall_at - 1) begin
                    stall_left = 10;
                end
                if (stall_left > 0) begin
                    pix_ready = 1'b0;
                    stall_left--;
                    stall_cycles++;
                    if (stall_left == 0) stall_done = 1'b1;
                end else if (ready_mode == 0) begin
                    pix_ready = 1'b1;
                end else begin
                    pix_ready = ($urandom_range(0, 3) != 0);
                end
                if (pix_valid === 1'b1) begin
                    if (exp_q.size() > 0) begin
                        f = exp_q[0];
                        check_value({name, "_pix_x"}, int'(pix_x), f.x);
                        check_value({name, "_pix_y"}, int'(pix_y), f.y);
                        check_value({name, "_pix_color"}, int'(pix_color), color);
                        if (ready_mode == 0 && stall_at == 0)
                            check_value({name, "_pix_cycle"}, cyc, f.k + 4);
                        if (pix_ready) void'(exp_q.pop_front());
                    end
                    if (pix_ready) hs++;
                end
                tick();
                cyc++;
            end
        end
        check_value({name, "_done_count"}, dones, 1);
        check_value({name, "_pix_count"}, hs, exp_total);
        if (stall_at > 0) check_value({name, "_stall_cycles"}, stall_cycles, 10);
        if (ready_mode == 0 && stall_at == 0) begin
            exp_done = (exp_kind == 1) ? 3 : ((exp_kind == 2) ? 4 : exp_n + 4);
            check_value({name, "_done_cycle"}, done_cyc, exp_done);
        end
    endtask

    initial begin
        int cx, cy;
        rst = 1'b1; tri_valid = 1'b0; pix_ready = 1'b0;
        tri_x0 = 10'sd0; tri_x1 = 10'sd0; tri_x2 = 10'sd0;
        tri_y0 = 9'sd0;  tri_y1 = 9'sd0;  tri_y2 = 9'sd0;
        tri_color = '0;
        tick();
        tick();
        check_value("rst_tri_ready", int'(tri_ready), 0);
        check_value("rst_pix_valid", int'(pix_valid), 0);
        check_value("rst_pix_x", int'(pix_x), 0);
        check_value("rst_pix_y", int'(pix_y), 0);
        check_value("rst_pix_color", int'(pix_color), 0);
        check_value("rst_done", int'(done), 0);
        rst = 1'b0;
        tick();
        check_value("post_rst_tri_ready", int'(tri_ready), 1);

        set_tri(0, 0, 4, 0, 0, 4);       run_tri(5, 0, 0, 0, "tri_ccw");
        set_tri(0, 0, 0, 4, 4, 0);       run_tri(5, 0, 0, 0, "tri_cw");
        set_tri(0, 0, 2, 2, 4, 4);       run_tri(3, 0, 0, 0, "collinear");
        set_tri(300, 170, 400, 170, 300, 250); run_tri(9, 0, 0, 0, "edge_clip");
        set_tri(-50, -20, -10, -30, -30, -5);  run_tri(2, 0, 0, 0, "offscreen");
        set_tri(0, 0, 4, 0, 0, 4);       run_tri(5, 0, 3, 0, "stall3");
        set_tri(0, 0, 4, 0, 0, 4);       run_tri(7, 0, 0, 5, "reset5");
        set_tri(10, 10, 16, 12, 11, 18); run_tri(6, 0, 0, 0, "after_rst");

        for (int i = 0; i < 20; i++) begin
            cx = int'($urandom_range(0, 400)) - 40;
            cy = int'($urandom_range(0, 240)) - 30;
            set_tri(cx + int'($urandom_range(0, 24)) - 12, cy + int'($urandom_range(0, 24)) - 12,
                    cx + int'($urandom_range(0, 24)) - 12, cy + int'($urandom_range(0, 24)) - 12,
                    cx + int'($urandom_range(0, 24)) - 12, cy + int'($urandom_range(0, 24)) - 12);
            run_tri(int'($urandom_range(0, 15)), i % 2, 0, 0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/triangle_rasterizer.md
# triangle_rasterizer

Consumes screen-space triangles from the 3D-to-2D projection stage and scan-converts each into a stream of covered pixel coordinates for the frame-buffer writer. Computes a clamped bounding box and three edge functions per triangle, then walks the box one candidate pixel per cycle, emitting covered pixels over a valid/ready handshake. It processes one triangle at a time and back-pressures the projection stage while busy.

## Interface
- H_RES, 320: screen width in pixels.
- V_RES, 180: screen height in pixels.
- COLOR_W, 4: per-triangle color/ID width.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- tri_valid  in  1  triangle present on tri_* inputs.
- tri_ready  out  1  block can accept a triangle (high only in IDLE).
- tri_x0, tri_x1, tri_x2  in  10 each  signed vertex x, two's complement.
- tri_y0, tri_y1, tri_y2  in  9 each  signed vertex y, two's complement.
- tri_color  in  COLOR_W  color carried to every emitted pixel.
- pix_valid  out  1  pixel present on pix_* outputs.
- pix_ready  in  1  consumer accepts the pixel.
- pix_x  out  9  pixel column, 0..H_RES-1.
- pix_y  out  8  pixel row, 0..V_RES-1.
- pix_color  out  COLOR_W  latched tri_color.
- done  out  1  one-cycle pulse when a triangle has been fully processed.

## Operation
- States: IDLE, BBOX, EDGE, SCAN, DRAIN.
- IDLE: tri_ready=1. On tri_valid && tri_ready, latch all vertices and the color, then go to BBOX.
- BBOX:
  - xmin/xmax and ymin/ymax are taken over the three vertices, then clamped to [0,H_RES-1] and [0,V_RES-1].
  - If the unclamped box lies entirely off-screen (xmax<0, xmin>H_RES-1, ymax<0 or ymin>V_RES-1), go straight to DRAIN with no pixels.
- EDGE:
  - For each edge (a,b) in (0,1), (1,2), (2,0): dx=xb-xa, dy=yb-ya (11-bit signed).
  - E at (xmin,ymin) = (xmin-xa)*dy - (ymin-ya)*dx, held as 24-bit signed; no overflow is possible at these widths.
  - area = E0 evaluated at vertex 2. If area==0 (degenerate), go to DRAIN with no pixels. Otherwise record sign = area<0.
- SCAN:
  - Visits (x,y) in raster order: x from xmin to xmax, y from ymin to ymax.
  - Edge values update incrementally: +dy per x step; a row step reloads the row-start value, then -dx.
  - A pixel is covered when all three E>=0 (sign=0) or all three E<=0 (sign=1). Edges are inclusive, so both windings give identical coverage.
  - A covered pixel is loaded into the output register. Uncovered candidates cost one cycle and emit nothing.
  - Scanning stalls while the output register is full and pix_ready=0.
  - After the last candidate (xmax,ymax), go to DRAIN.
- DRAIN: wait until the output register is empty, pulse done for one cycle, return to IDLE.
- Reset, including mid-triangle: next state is IDLE; the current triangle is discarded with no done pulse.

## Timing
- Reset values: tri_ready=0 during the reset cycle and 1 in the first cycle after; pix_valid=0; pix_x=0; pix_y=0; pix_color=0; done=0.
- Accept at cycle T: BBOX at T+1, EDGE at T+2, first candidate evaluated at T+3. The earliest pix_valid is T+4.
- Throughput: one candidate per cycle with pix_ready held high.
- pix_valid, once asserted, holds with pix_x, pix_y and pix_color stable until the cycle in which pix_ready=1.
- The output register may be refilled in the same cycle it is consumed, so there are no bubbles.
- done asserts the cycle after the final pixel handshake. For an empty or degenerate triangle, done asserts at T+3 (off-screen) or T+4 (degenerate).
- tri_ready rises in the cycle after done.
- pix_ready is ignored while pix_valid=0. tri_* inputs are ignored outside IDLE.

## Test plan
- Triangle (0,0),(4,0),(0,4), color 5, pix_ready=1 -> exactly 15 pixels (x+y<=4), in raster order, all with pix_color=5; first pix_valid at T+4; done once.
- Same vertices with reversed winding (0,0),(0,4),(4,0) -> the identical 15 pixels in the same order.
- Collinear triangle (0,0),(2,2),(4,4) -> zero pixels; done at T+4; tri_ready high at T+5.
- Triangle (300,170),(400,170),(300,250) -> no pixel with x>319 or y>179; the pixel set matches the reference edge-function model restricted to the screen.
- Triangle (0,0),(4,0),(0,4) with pix_ready low for 10 cycles at the 3rd pixel -> the 3rd pixel is held stable for 10 cycles; the full 15-pixel sequence and count are unchanged.
- Reset asserted at the 5th pixel of a triangle -> pix_valid=0 the next cycle, no done pulse; a new triangle is accepted afterwards and rasterizes correctly.
